// File: rtl/of_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : of_stage_pkg
//  Purpose  : Shared widths, condition codes, write-control bit indices and
//             the flag record used by the operand-fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
package of_stage_pkg;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int NREG = 16;

    // Condition codes; 9..15 are never taken
    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_MI = 4'd3;
    localparam logic [3:0] COND_PL = 4'd4;
    localparam logic [3:0] COND_CS = 4'd5;
    localparam logic [3:0] COND_CC = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;

    // Bit positions inside the write-back write-control field
    localparam int W_REG   = 0;
    localparam int W_FLAGS = 1;
    localparam int W_SZ    = 2;

    typedef struct packed {
        logic o;
        logic s;
        logic c;
        logic z;
    } flags_t;

    function automatic logic cond_eval(input logic [3:0] cond, input flags_t f);
        logic r;
        case (cond)
            COND_AL: r = 1'b1;
            COND_EQ: r = f.z;
            COND_NE: r = ~f.z;
            COND_MI: r = f.s;
            COND_PL: r = ~f.s;
            COND_CS: r = f.c;
            COND_CC: r = ~f.c;
            COND_VS: r = f.o;
            COND_VC: r = ~f.o;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/of_stage_rf_bank.sv
`default_nettype none
// ============================================================================
//  Module   : rf_bank
//  Purpose  : 16x32 register array plus O/S/C/Z flag register with the
//             write-back port and two write-through (bypassed) read ports.
//  Revision : 1.0  initial release
// ============================================================================
module rf_bank
    import of_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] wb_rc,
    input  logic [DW-1:0] wb_data,
    input  logic [2:0]    wb_w_rf,
    input  flags_t        wb_flags,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    output logic          reg_wr,
    output flags_t        flags_byp,
    output flags_t        flags
);

    logic [DW-1:0] r_regs [NREG];
    flags_t        r_flags;
    flags_t        w_flags_nxt;
    logic          w_reg_wr;

    // R0 is hard-wired zero, so a write aimed at it never happens
    assign w_reg_wr = wb_w_rf[W_REG] && (wb_rc != '0);
    assign reg_wr   = w_reg_wr;

    // Register array write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_reg_wr) begin
            r_regs[wb_rc] <= wb_data;
        end
    end

    // Next flag value: full update beats the S/Z-only update
    always_comb begin
        w_flags_nxt = r_flags;
        if (wb_w_rf[W_FLAGS]) begin
            w_flags_nxt = wb_flags;
        end else if (wb_w_rf[W_SZ]) begin
            w_flags_nxt.s = wb_flags.s;
            w_flags_nxt.z = wb_flags.z;
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_flags <= '0;
        else        r_flags <= w_flags_nxt;
    end

    assign rd_a = (ra == '0) ? '0 :
                  (w_reg_wr && (wb_rc == ra)) ? wb_data : r_regs[ra];
    assign rd_b = (rb == '0) ? '0 :
                  (w_reg_wr && (wb_rc == rb)) ? wb_data : r_regs[rb];

    assign flags_byp = w_flags_nxt;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: rtl/of_stage.sv
`default_nettype none
// ============================================================================
//  Module   : of_stage
//  Purpose  : Operand fetch: bypassed register/flag reads, branch condition
//             evaluation and the OF/EX pipeline register with stall snooping.
//  Revision : 1.0  initial release
// ============================================================================
module of_stage
    import of_stage_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [AW-1:0] id_RA,
    input  logic [AW-1:0] id_RB,
    input  logic [AW-1:0] id_RC,
    input  logic [3:0]    id_cond,
    input  logic [AW-1:0] wb_RC,
    input  logic [DW-1:0] wb_data,
    input  logic [2:0]    wb_W_RF,
    input  logic          wb_O,
    input  logic          wb_S,
    input  logic          wb_C,
    input  logic          wb_Z,
    output logic          of_valid,
    output logic [DW-1:0] of_A,
    output logic [DW-1:0] of_B,
    output logic [AW-1:0] of_RC,
    output logic          of_take,
    output logic          rf_O,
    output logic          rf_S,
    output logic          rf_C,
    output logic          rf_Z
);

    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;
    logic          w_reg_wr;
    flags_t        w_flags_byp;
    flags_t        w_flags;
    flags_t        w_wb_flags;

    logic          r_valid;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [AW-1:0] r_rc;
    logic          r_take;
    logic [AW-1:0] r_ra;
    logic [AW-1:0] r_rb;
    logic [3:0]    r_cond;

    assign w_wb_flags = '{o: wb_O, s: wb_S, c: wb_C, z: wb_Z};

    rf_bank u_rf_bank (
        .clk       (CLK),
        .rst_n     (RST_n),
        .wb_rc     (wb_RC),
        .wb_data   (wb_data),
        .wb_w_rf   (wb_W_RF),
        .wb_flags  (w_wb_flags),
        .ra        (id_RA),
        .rb        (id_RB),
        .rd_a      (w_rd_a),
        .rd_b      (w_rd_b),
        .reg_wr    (w_reg_wr),
        .flags_byp (w_flags_byp),
        .flags     (w_flags)
    );

    // OF/EX register: flush > stall (with write-back snoop) > capture.
    // During stall the condition is re-evaluated on the bypassed flags every
    // cycle; with no flag write those equal the flags it was captured with.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_rc    <= '0;
            r_take  <= 1'b0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_cond  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_rc    <= '0;
            r_take  <= 1'b0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_cond  <= '0;
        end else if (stall) begin
            if (w_reg_wr && (wb_RC == r_ra)) r_a <= wb_data;
            if (w_reg_wr && (wb_RC == r_rb)) r_b <= wb_data;
            r_take <= cond_eval(r_cond, w_flags_byp);
        end else begin
            r_valid <= id_valid;
            r_a     <= w_rd_a;
            r_b     <= w_rd_b;
            r_rc    <= id_RC;
            r_take  <= cond_eval(id_cond, w_flags_byp);
            r_ra    <= id_RA;
            r_rb    <= id_RB;
            r_cond  <= id_cond;
        end
    end

    assign of_valid = r_valid;
    assign of_A     = r_a;
    assign of_B     = r_b;
    assign of_RC    = r_rc;
    assign of_take  = r_take;
    assign rf_O     = w_flags.o;
    assign rf_S     = w_flags.s;
    assign rf_C     = w_flags.c;
    assign rf_Z     = w_flags.z;

endmodule
`default_nettype wire
